// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// LS has strict priority; each access is BUS (ack or timeout), then one RESP cycle.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_done,
  output logic          stallreq_if,
  output logic          stallreq_ls,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS_LS, BUS_IF, RESP} state_t;
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_cmd_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  bus_cmd_t      cmd, cmd_n;
  logic [DW-1:0] if_rdata_n, ls_rdata_n;
  logic          if_done_n, ls_done_n, bus_err_n;
  logic          expired;

  assign bus_req     = cmd.req;
  assign bus_we      = cmd.we;
  assign bus_addr    = cmd.addr;
  assign bus_wdata   = cmd.wdata;
  assign stallreq_if = if_req & ~if_done;
  assign stallreq_ls = ls_req & ~ls_done;
  assign expired     = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd      <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cmd      <= cmd_n;
      if_rdata <= if_rdata_n;
      ls_rdata <= ls_rdata_n;
      if_done  <= if_done_n;
      ls_done  <= ls_done_n;
      bus_err  <= bus_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cmd_n      = cmd;
    if_rdata_n = if_rdata;
    ls_rdata_n = ls_rdata;
    if_done_n  = 1'b0;
    ls_done_n  = 1'b0;
    bus_err_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (ls_req) begin
          cmd_n   = '{req: 1'b1, we: ls_we, addr: ls_addr, wdata: ls_wdata};
          state_n = BUS_LS;
        end else if (if_req) begin
          cmd_n   = '{req: 1'b1, we: 1'b0, addr: if_addr, wdata: '0};
          state_n = BUS_IF;
        end
      end
      BUS_LS, BUS_IF: begin
        cnt_n = cnt + CW'(1);
        // ack wins over timeout; an aborted access returns zero data
        if (bus_ack || expired) begin
          state_n   = RESP;
          cnt_n     = '0;
          cmd_n     = '0;
          bus_err_n = ~bus_ack;
          if (state == BUS_LS) begin
            ls_done_n  = 1'b1;
            ls_rdata_n = (bus_ack && !cmd.we) ? bus_rdata : '0;
          end else begin
            if_done_n  = 1'b1;
            if_rdata_n = bus_ack ? bus_rdata : '0;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// plus literal latency/data expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, TO = 15;

  logic          clk = 1'b0, rst = 1'b1;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0, bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] if_rdata, ls_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          if_done, ls_done, stallreq_if, stallreq_ls, bus_req, bus_we, bus_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .stallreq_if(stallreq_if), .stallreq_ls(stallreq_ls),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory responder: acks after ack_wait bus cycles, never when negative
  int ack_wait = 0, bcnt = 0;
  always @(posedge clk) begin
    #2;
    if (bus_req === 1'b1) begin
      bus_ack = (ack_wait >= 0 && bcnt == ack_wait);
      bcnt++;
    end else begin
      bus_ack = 1'b0;
      bcnt = 0;
    end
  end

  // transaction model: owner of the port, bus cycles spent, response pending
  int            m_owner = 0, m_spent = 0;
  bit            m_resp = 1'b0;
  logic          e_breq = 0, e_bwe = 0, e_ifd = 0, e_lsd = 0, e_err = 0;
  logic [15:0]   e_baddr = 0, e_bwdata = 0, e_ifr = 0, e_lsr = 0;
  always @(posedge clk) begin
    e_ifd = 0; e_lsd = 0; e_err = 0;
    if (rst) begin
      m_owner = 0; m_resp = 0;
      e_breq = 0; e_bwe = 0; e_baddr = 0; e_bwdata = 0; e_ifr = 0; e_lsr = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_owner != 0) begin
      m_spent++;
      if (bus_ack || m_spent == TO) begin
        if (m_owner == 1) begin
          e_lsd = 1; e_lsr = (bus_ack && !e_bwe) ? bus_rdata : 16'h0;
        end else begin
          e_ifd = 1; e_ifr = bus_ack ? bus_rdata : 16'h0;
        end
        e_err = !bus_ack;
        m_owner = 0; m_resp = 1;
        e_breq = 0; e_bwe = 0; e_baddr = 0; e_bwdata = 0;
      end
    end else if (ls_req) begin
      m_owner = 1; m_spent = 0;
      e_breq = 1; e_bwe = ls_we; e_baddr = ls_addr; e_bwdata = ls_wdata;
    end else if (if_req) begin
      m_owner = 2; m_spent = 0;
      e_breq = 1; e_bwe = 0; e_baddr = if_addr; e_bwdata = 0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bus_req", bus_req, e_breq);
      chk("bus_we", bus_we, e_bwe);
      chk("bus_addr", bus_addr, e_baddr);
      chk("bus_wdata", bus_wdata, e_bwdata);
      chk("if_done", if_done, e_ifd);
      chk("ls_done", ls_done, e_lsd);
      chk("if_rdata", if_rdata, e_ifr);
      chk("ls_rdata", ls_rdata, e_lsr);
      chk("bus_err", bus_err, e_err);
      chk("stallreq_if", stallreq_if, if_req & ~e_ifd);
      chk("stallreq_ls", stallreq_ls, ls_req & ~e_lsd);
    end
  end

  // one access; cycle 0 is the cycle the request is raised
  task automatic run(input bit is_ls, input bit we, input logic [15:0] addr, wdata,
                     input int wait_c, output int done_at, bus_cyc, stall_cyc,
                     output logic err, output logic [15:0] first_addr);
    ack_wait = wait_c;
    @(posedge clk); #2;
    if (is_ls) begin ls_req = 1; ls_we = we; ls_addr = addr; ls_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    done_at = -1; bus_cyc = 0; stall_cyc = 0; err = 0; first_addr = 16'hxxxx;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (bus_req) begin
        if (bus_cyc == 0) first_addr = bus_addr;
        bus_cyc++;
      end
      if (is_ls ? stallreq_ls : stallreq_if) stall_cyc++;
      if (is_ls ? ls_done : if_done) begin done_at = i; err = bus_err; end
      if (i == 1) begin ls_addr = ~addr; if_addr = ~addr; ls_wdata = ~wdata; end
    end
    @(posedge clk); #2;
    ls_req = 0; if_req = 0; ls_we = 0;
    if (done_at < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int d, bc, sc, lsd, ifd, ifbus;
  logic er;
  logic [15:0] fa;
  initial begin
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    @(posedge clk); #2 rst = 0;

    // zero-wait load
    bus_rdata = 16'hBEEF;
    run(1, 0, 16'h0040, 16'h0, 0, d, bc, sc, er, fa);
    chk("zw_done_at", d, 2);
    chk("zw_bus_cycles", bc, 1);
    chk("zw_stall_cycles", sc, 2);
    chk("zw_addr", fa, 16'h0040);
    chk("zw_rdata", ls_rdata, 16'hBEEF);

    // wait-state store
    run(1, 1, 16'h0100, 16'h1234, 3, d, bc, sc, er, fa);
    chk("st_bus_cycles", bc, 4);
    chk("st_done_at", d, 5);
    chk("st_err", er, 0);
    chk("st_rdata", ls_rdata, 16'h0000);

    // contention: LS first, IF issued after LS's RESP + IDLE
    ack_wait = 0; bus_rdata = 16'h1111;
    @(posedge clk); #2;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0010; if_req = 1; if_addr = 16'h0020;
    lsd = -1; ifd = -1; ifbus = -1;
    for (int i = 0; i < 40 && ifd < 0; i++) begin
      @(negedge clk);
      if (ls_done) lsd = i;
      if (if_done) ifd = i;
      if (bus_req && bus_addr == 16'h0020 && ifbus < 0) ifbus = i;
      if (ls_done) begin @(posedge clk); #2; ls_req = 0; bus_rdata = 16'h2222; end
    end
    @(posedge clk); #2; if_req = 0; ls_req = 0;
    chk("ct_ls_done_at", lsd, 2);
    chk("ct_if_bus_at", ifbus, 4);
    chk("ct_if_done_at", ifd, 5);
    chk("ct_ls_rdata", ls_rdata, 16'h1111);
    chk("ct_if_rdata", if_rdata, 16'h2222);

    // timeout on fetch
    bus_rdata = 16'hDEAD;
    run(0, 0, 16'h0200, 16'h0, -1, d, bc, sc, er, fa);
    chk("to_bus_cycles", bc, 15);
    chk("to_done_at", d, 16);
    chk("to_err", er, 1);
    chk("to_rdata", if_rdata, 16'h0000);

    // ack on the last allowed cycle
    bus_rdata = 16'hCAFE;
    run(1, 0, 16'h0300, 16'h0, 14, d, bc, sc, er, fa);
    chk("bd_bus_cycles", bc, 15);
    chk("bd_done_at", d, 16);
    chk("bd_err", er, 0);
    chk("bd_rdata", ls_rdata, 16'hCAFE);

    // reset in the 2nd bus cycle
    ack_wait = -1;
    @(posedge clk); #2; if_req = 1; if_addr = 16'h0500;
    @(posedge clk); @(posedge clk); #2; rst = 1;
    @(posedge clk); #2; rst = 0; if_req = 0;
    @(negedge clk);
    chk("rm_bus_req", bus_req, 0);
    chk("rm_if_done", if_done, 0);
    chk("rm_ls_rdata", ls_rdata, 0);
    sc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_done || ls_done) sc++;
    end
    chk("rm_no_done", sc, 0);

    // fresh fetch after reset
    bus_rdata = 16'h1357;
    run(0, 0, 16'h0044, 16'h0, 0, d, bc, sc, er, fa);
    chk("fr_done_at", d, 2);
    chk("fr_rdata", if_rdata, 16'h1357);
    chk("fr_addr", fa, 16'h0044);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 16-bit external memory port between instruction fetch (IF) and the load/store path of the MEM stage. It runs a request/acknowledge bus sequencer with a timeout, returns read data and a one-cycle done pulse to the winning requester, and raises stall requests. The pipeline control unit turns those stall requests into the `stall[5:0]` vector that freezes or bubbles the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 15: maximum cycles `bus_req` stays high without `bus_ack` before the access is aborted. Must be ≥1. Counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `if_req` in 1: fetch request. Held high until `if_done`.
- `if_addr` in AW: fetch address.
- `if_rdata` out DW: fetched word. Valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse for IF.
- `ls_req` in 1: load/store request. Held high until `ls_done`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_addr` in AW: load/store address.
- `ls_wdata` in DW: store data.
- `ls_rdata` out DW: load data. Valid while `ls_done`=1.
- `ls_done` out 1: one-cycle completion pulse for LS.
- `stallreq_if` out 1: `if_req & ~if_done`. Combinational.
- `stallreq_ls` out 1: `ls_req & ~ls_done`. Combinational.
- `bus_req` out 1: external access strobe.
- `bus_we` out 1: external write enable.
- `bus_addr` out AW: external address.
- `bus_wdata` out DW: external write data.
- `bus_rdata` in DW: external read data. Sampled on the `bus_ack` cycle.
- `bus_ack` in 1: external completion. May be high in the first `bus_req` cycle.
- `bus_err` out 1: one-cycle pulse when an access times out.

## Operation
- FSM states: IDLE, BUS_LS, BUS_IF, RESP.
- **IDLE**
  - `ls_req`=1: latch `ls_addr`, `ls_wdata` and `ls_we` into the bus registers; go to BUS_LS.
  - else `if_req`=1: latch `if_addr` with `we`=0; go to BUS_IF.
  - else stay in IDLE.
  - LS has strict priority: it belongs to the older instruction. IF cannot starve, because a pending LS stalls fetch anyway.
- **BUS_LS / BUS_IF**
  - `bus_req`=1; `bus_addr`, `bus_wdata` and `bus_we` are held constant.
  - Cycle counter `cnt` starts at 0 on entry and increments each cycle.
  - `bus_ack`=1: capture `bus_rdata` (zero for stores) into the owner's rdata register; go to RESP.
  - else if `cnt`==TIMEOUT-1: capture 0, set the error flag; go to RESP.
  - `bus_ack` takes precedence over timeout in the same cycle.
- **RESP**
  - Owner's done=1 for exactly one cycle; `bus_err`=1 that cycle if the access aborted.
  - No new access is issued; return to IDLE.
  - This cycle lets the requester drop or change its request, so the same request is never re-issued.
- `bus_req`, `bus_we`, `bus_addr` and `bus_wdata` are 0 outside the BUS states.
- `if_rdata` and `ls_rdata` hold their value until the next capture for the same requester.
- Requester inputs are ignored outside IDLE. Changing `*_addr` mid-access has no effect.

## Timing
- Reset values: state IDLE, `cnt`=0, and every registered output 0 (`bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `if_rdata`, `ls_rdata`, `if_done`, `ls_done`, `bus_err`).
- Reset mid-access:
  - `bus_req` is 0 in the cycle after `rst` is sampled.
  - No done pulse is produced and any pending data is discarded.
- Latency: request seen in IDLE at cycle 0 → `bus_req` at cycle 1 → ack at cycle 1+k → done at cycle 2+k.
  - Zero-wait memory: done at cycle 2.
  - Back-to-back accesses: minimum 3 cycles apart (BUS, RESP, IDLE).
- Timeout: `bus_req` is high for exactly TIMEOUT cycles; done and `bus_err` follow in the next cycle.
- `stallreq_*` are high from the first cycle of a request through the cycle before done, and low in the done cycle.
- LS and IF both requesting in IDLE: LS is served first. IF is issued in the IDLE cycle that follows LS's RESP, provided `if_req` is still high.

## Test plan
- **Zero-wait load:** `ls_req`=1, `ls_we`=0, `ls_addr`=0x0040, `bus_ack` tied 1, `bus_rdata`=0xBEEF → `bus_req` 1 cycle with `bus_addr`=0x0040; `ls_done` 2 cycles after the request with `ls_rdata`=0xBEEF; `stallreq_ls` high 2 cycles.
- **Wait-state store:** `ls_we`=1, `ls_addr`=0x0100, `ls_wdata`=0x1234, ack after 3 wait cycles → `bus_req`=`bus_we`=1 for 4 cycles with stable addr/data; `ls_done` the next cycle; `bus_err`=0.
- **Contention:** `if_req` and `ls_req` rise in the same cycle, zero-wait memory → LS completes first; IF `bus_req` starts in the cycle after `ls_done` + 1; `if_done` arrives 3 cycles after `ls_done`.
- **Timeout:** TIMEOUT=15, `bus_ack` never asserted → `bus_req` high exactly 15 cycles; then `if_done`=1 with `if_rdata`=0x0000 and `bus_err`=1 for one cycle.
- **Ack at the timeout boundary:** `bus_ack` arrives on the last allowed cycle (`cnt`=14) → data captured, `bus_err`=0.
- **Reset mid-access:** `rst` pulsed in the 2nd BUS cycle → all outputs 0 the next cycle; no done pulse; a fresh request afterwards completes normally.
